// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain engine for the async FIFO (read clock domain).
// Issues read strobes against the FIFO empty flag, absorbs the one-cycle memory
// read latency and presents words as a valid/ready stream through a 2-entry
// buffer (head + skid). Full throughput with no bubbles under continuous ready.
// Optional feature macro: FIFO_RD_CNT_EN adds the rd_cnt delivered-word counter.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no word buffered, out_valid low
// S_ONE   | head holds the presented word
// S_TWO   | head presented, skid holds the next word
module fifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        buf_level
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CNT_W-1:0]  rd_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] skid;
    logic              inflight;
    logic              pop;
    logic [2:0]        occ;

    assign pop      = out_valid && out_ready;
    assign out_data = head;

    // Occupancy after this cycle's pop; a read may issue only if a slot remains
    // for the word that will land next cycle. out_ready/fifo_empty feed rd_en directly.
    assign occ   = {1'b0, buf_level} + {2'b00, inflight} - {2'b00, pop};
    assign rd_en = rst_n && !fifo_empty && (occ <= 3'd1);

    // Buffer FSM: captures the landing word into head or skid and tracks level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_EMPTY;
            head      <= '0;
            skid      <= '0;
            inflight  <= 1'b0;
            out_valid <= 1'b0;
            buf_level <= 2'd0;
        end else begin
            inflight <= rd_en;
            case (state)
                S_EMPTY: begin
                    if (inflight) begin
                        head      <= rd_data;
                        state     <= S_ONE;
                        out_valid <= 1'b1;
                        buf_level <= 2'd1;
                    end
                end
                S_ONE: begin
                    if (inflight && pop) begin
                        head <= rd_data;
                    end else if (inflight) begin
                        skid      <= rd_data;
                        state     <= S_TWO;
                        buf_level <= 2'd2;
                    end else if (pop) begin
                        state     <= S_EMPTY;
                        out_valid <= 1'b0;
                        buf_level <= 2'd0;
                    end
                end
                S_TWO: begin
                    // A landing word without a pop cannot happen here: the issue
                    // rule never lets occupancy exceed two.
                    if (pop) begin
                        head <= skid;
                        if (inflight) begin
                            skid <= rd_data;
                        end else begin
                            state     <= S_ONE;
                            buf_level <= 2'd1;
                        end
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    out_valid <= 1'b0;
                    buf_level <= 2'd0;
                end
            endcase
        end
    end

`ifdef FIFO_RD_CNT_EN
    // Delivered-word counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
        end else if (pop) begin
            rd_cnt <= rd_cnt + 1'b1;
        end
    end
`else
    // CNT_W only sizes rd_cnt; nothing to build without the counter.
    if (CNT_W > 0) begin : g_no_cnt
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a simple FIFO memory harness and an
// ordering scoreboard.
module tb_fifo_rd_stream;

    logic       clk;
    logic       rst_n;
    logic       fifo_empty;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] buf_level;
`ifdef FIFO_RD_CNT_EN
    logic [15:0] rd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:4095];
    int         rptr;
    int         wr_cnt;
    logic       stall_empty;
    logic       inflight_tb;
    int         npops;
    logic [7:0] q [$];

    fifo_rd_stream #(.DATA_W(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .buf_level  (buf_level)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_cnt     (rd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        fifo_empty = stall_empty || (rptr >= wr_cnt);
    endtask

    task automatic load(input int n, input logic [7:0] base);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = base + i[7:0];
            mem[wr_cnt + i] = v;
        end
        wr_cnt += n;
        upd_empty();
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock cycle: entered and left just after a negedge with inputs set.
    task automatic cyc();
        logic       pe;
        logic       pp;
        logic       ph;
        logic [7:0] pd;
        logic [7:0] exp_w;
        #1;
        pe = rd_en;
        pp = out_valid && out_ready;
        ph = out_valid && !out_ready;
        pd = out_data;
        check("rd_en_while_empty", {31'b0, pe && fifo_empty}, 32'd0);
        check("overflow", {31'b0, inflight_tb && (buf_level == 2'd2) && !pp}, 32'd0);
        if (pp) begin
            check("pop_has_word", {31'b0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                exp_w = q.pop_front();
                check("order", {24'b0, out_data}, {24'b0, exp_w});
            end
            npops++;
        end
        @(posedge clk);
        #1;
        inflight_tb = pe;
        if (pe) begin
            rd_data = mem[rptr];
            q.push_back(mem[rptr]);
            rptr++;
        end
        upd_empty();
        if (ph) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_data", {24'b0, out_data}, {24'b0, pd});
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        rptr        = 0;
        wr_cnt      = 0;
        q.delete();
        rd_data     = 8'h00;
        stall_empty = 1'b0;
        inflight_tb = 1'b0;
        npops       = 0;
        out_ready   = 1'b0;
        upd_empty();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        rd_data     = 8'h00;
        stall_empty = 1'b0;
        rptr        = 0;
        wr_cnt      = 0;
        inflight_tb = 1'b0;
        npops       = 0;
        fifo_empty  = 1'b0;
        // rd_en must stay low during reset even with data available
        #12;
        check("rst_rd_en", {31'b0, rd_en}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", {24'b0, out_data}, 32'd0);
        check("rst_level", {30'b0, buf_level}, 32'd0);
`ifdef FIFO_RD_CNT_EN
        check("rst_cnt", {16'b0, rd_cnt}, 32'd0);
`endif

        // Two-word latency test
        do_reset();
        out_ready = 1'b1;
        load(2, 8'h11);
        mem[1] = 8'h22;
        settle();
        check("t1_c0_rd_en", {31'b0, rd_en}, 32'd1);
        check("t1_c0_valid", {31'b0, out_valid}, 32'd0);
        cyc();
        settle();
        check("t1_c1_rd_en", {31'b0, rd_en}, 32'd1);
        check("t1_c1_valid", {31'b0, out_valid}, 32'd0);
        cyc();
        settle();
        check("t1_c2_valid", {31'b0, out_valid}, 32'd1);
        check("t1_c2_data", {24'b0, out_data}, 32'h11);
        check("t1_c2_level", {30'b0, buf_level}, 32'd1);
        check("t1_c2_rd_en", {31'b0, rd_en}, 32'd0);
        cyc();
        settle();
        check("t1_c3_valid", {31'b0, out_valid}, 32'd1);
        check("t1_c3_data", {24'b0, out_data}, 32'h22);
        cyc();
        settle();
        check("t1_c4_valid", {31'b0, out_valid}, 32'd0);
        check("t1_c4_level", {30'b0, buf_level}, 32'd0);

        // 64-word continuous stream: pops at relative cycles 2..65
        do_reset();
        out_ready = 1'b1;
        load(64, 8'h00);
        cyc();
        cyc();
        npops = 0;
        for (int i = 0; i < 64; i++) begin
            settle();
            check("t2_no_bubble", {31'b0, out_valid}, 32'd1);
            cyc();
        end
        check("t2_pops", npops, 32'd64);
        settle();
        check("t2_drained", {31'b0, out_valid}, 32'd0);
`ifdef FIFO_RD_CNT_EN
        check("t2_cnt", {16'b0, rd_cnt}, 32'd64);
`endif

        // Stall mid-stream for 10 cycles
        do_reset();
        out_ready = 1'b1;
        load(20, 8'h40);
        for (int i = 0; i < 5; i++) cyc();
        check("t3_pre_pops", npops, 32'd3);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        settle();
        check("t3_level", {30'b0, buf_level}, 32'd2);
        check("t3_rd_en", {31'b0, rd_en}, 32'd0);
        check("t3_data", {24'b0, out_data}, 32'h43);
        check("t3_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        settle();
        check("t3_release_rd_en", {31'b0, rd_en}, 32'd1);
        for (int i = 0; i < 30; i++) cyc();
        check("t3_pops", npops, 32'd20);
        check("t3_q_empty", q.size(), 32'd0);
        check("t3_level_end", {30'b0, buf_level}, 32'd0);

        // FIFO empties after 3 words
        do_reset();
        out_ready = 1'b1;
        load(3, 8'hA0);
        for (int i = 0; i < 10; i++) cyc();
        settle();
        check("t4_pops", npops, 32'd3);
        check("t4_valid", {31'b0, out_valid}, 32'd0);
        check("t4_level", {30'b0, buf_level}, 32'd0);
        check("t4_rd_en", {31'b0, rd_en}, 32'd0);

        // Random ready / empty
        do_reset();
        load(4000, 8'h00);
        for (int i = 0; i < 2000; i++) begin
            out_ready   = 1'($urandom_range(0, 1));
            stall_empty = ($urandom_range(0, 3) == 0);
            upd_empty();
            cyc();
        end
        stall_empty = 1'b1;
        out_ready   = 1'b1;
        upd_empty();
        for (int i = 0; i < 5; i++) cyc();
        check("t5_q_empty", q.size(), 32'd0);
        check("t5_level", {30'b0, buf_level}, 32'd0);

        // Reset while the buffer is full
        do_reset();
        load(10, 8'hC0);
        for (int i = 0; i < 3; i++) cyc();
        settle();
        check("t6_level_pre", {30'b0, buf_level}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'b0, out_valid}, 32'd0);
        check("t6_level", {30'b0, buf_level}, 32'd0);
        check("t6_rd_en", {31'b0, rd_en}, 32'd0);
        check("t6_data", {24'b0, out_data}, 32'd0);
`ifdef FIFO_RD_CNT_EN
        check("t6_cnt", {16'b0, rd_cnt}, 32'd0);
`endif
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
